// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle core:
// phase state enum, instruction class/op/cond codes, flag bit positions.
package multicycle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_P1,
      ST_P2,
      ST_P3,
      ST_P4,
      ST_P5,
      ST_HALT
   } state_e;

   localparam logic [1:0] CL_LD   = 2'b00;
   localparam logic [1:0] CL_ST   = 2'b01;
   localparam logic [1:0] CL_MISC = 2'b10;
   localparam logic [1:0] CL_ALU  = 2'b11;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_MOV = 4'd6;
   localparam logic [3:0] OP_SLL = 4'd8;
   localparam logic [3:0] OP_SLR = 4'd9;
   localparam logic [3:0] OP_SRL = 4'd10;
   localparam logic [3:0] OP_SRA = 4'd11;
   localparam logic [3:0] OP_HLT = 4'd15;

   localparam logic [2:0] MI_LI = 3'b000;
   localparam logic [2:0] MI_B  = 3'b100;
   localparam logic [2:0] MI_BC = 3'b111;

   localparam logic [2:0] CC_BE  = 3'b000;
   localparam logic [2:0] CC_BLT = 3'b001;
   localparam logic [2:0] CC_BLE = 3'b010;
   localparam logic [2:0] CC_BNE = 3'b011;

   localparam int F_S = 3;
   localparam int F_Z = 2;
   localparam int F_C = 1;
   localparam int F_V = 0;

endpackage

// File: rtl/multicycle_core_alu.sv
// Combinational ALU/shifter. x = rd value, y = rs value, d = shift count.
// Outputs: res, flg {S,Z,C,V}, wr (res goes to rd), fset (flags update).
module core_alu
   import multicycle_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic [3:0]        d,
   output logic [DATA_W-1:0] res,
   output logic [3:0]        flg,
   output logic              wr,
   output logic              fset
);

   localparam int MSB = DATA_W - 1;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   dif;
   logic [DATA_W:0]   lsh;
   logic [DATA_W:0]   rsh;
   logic [DATA_W:0]   ash;
   logic [DATA_W-1:0] rot;
   logic              c;
   logic              v;

   always_comb begin
      sum = {1'b0, x} + {1'b0, y};
      // top bit of dif is the borrow
      dif = {1'b0, x} - {1'b0, y};
      // extra bit catches the last bit shifted out (0 when d=0)
      lsh = {1'b0, x} << d;
      rsh = {x, 1'b0} >> d;
      ash = $signed({x, 1'b0}) >>> d;
      rot = lsh[MSB:0] | (x >> (DATA_W - int'(d)));
      res  = '0;
      c    = 1'b0;
      v    = 1'b0;
      wr   = 1'b1;
      fset = 1'b1;
      case (op)
         OP_ADD: begin
            res = sum[MSB:0];
            c   = sum[DATA_W];
            v   = (x[MSB] == y[MSB]) && (res[MSB] != x[MSB]);
         end
         OP_SUB, OP_CMP: begin
            res = dif[MSB:0];
            c   = dif[DATA_W];
            v   = (x[MSB] != y[MSB]) && (res[MSB] != x[MSB]);
            wr  = (op == OP_SUB);
         end
         OP_AND: res = x & y;
         OP_OR:  res = x | y;
         OP_XOR: res = x ^ y;
         OP_MOV: res = y;
         OP_SLL: begin
            res = lsh[MSB:0];
            c   = lsh[DATA_W];
         end
         OP_SLR: begin
            res = rot;
            c   = lsh[DATA_W];
         end
         OP_SRL: begin
            res = rsh[DATA_W:1];
            c   = rsh[0];
         end
         OP_SRA: begin
            res = ash[DATA_W:1];
            c   = ash[0];
         end
         default: begin
            wr   = 1'b0;
            fset = 1'b0;
         end
      endcase
      flg = {res[MSB], ~|res, c, v};
   end

endmodule

// File: rtl/multicycle_core.sv
// Five-phase multicycle core with stallable single-port memory handshake.
// Ports: clock/reset(async low), exec, m_* memory bus, phase/running/halted/pc/flags status.
module multicycle_core
   import multicycle_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 12,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              exec,
   input  logic [DATA_W-1:0] m_q,
   input  logic              m_ack,
   output logic              m_req,
   output logic              m_wren,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_data,
   output logic [4:0]        phase,
   output logic              running,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        flags
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] res_q, res_d, wdata_q, wdata_d;
   logic [DATA_W-1:0] rf_q [8];
   logic [DATA_W-1:0] rf_d [8];
   logic [3:0]        flags_q, flags_d;
   logic              wr_q, wr_d, stop_q, stop_d;
   logic              halt_q, halt_d, req_q, req_d;
   logic              wren_q, wren_d;

   logic [1:0]        cls;
   logic [2:0]        fa, fb;
   logic [DATA_W-1:0] sext8;
   logic [ADDR_W-1:0] ea;
   logic              take, is_hlt;
   logic [DATA_W-1:0] alu_res;
   logic [3:0]        alu_flg;
   logic              alu_wr, alu_fset;

   assign cls    = ir_q[15:14];
   assign fa     = ir_q[13:11];
   assign fb     = ir_q[10:8];
   assign sext8  = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};
   assign ea     = b_q[ADDR_W-1:0] + sext8[ADDR_W-1:0];
   assign is_hlt = (cls == CL_ALU) && (ir_q[7:4] == OP_HLT);

   core_alu #(.DATA_W(DATA_W)) u_alu (
      .op   (ir_q[7:4]),
      .x    (b_q),
      .y    (a_q),
      .d    (ir_q[3:0]),
      .res  (alu_res),
      .flg  (alu_flg),
      .wr   (alu_wr),
      .fset (alu_fset)
   );

   always_comb begin
      take = 1'b0;
      if (cls == CL_MISC) begin
         if (fa == MI_B) begin
            take = 1'b1;
         end else if (fa == MI_BC) begin
            case (fb)
               CC_BE:   take = flags_q[F_Z];
               CC_BLT:  take = flags_q[F_S] ^ flags_q[F_V];
               CC_BLE:  take = flags_q[F_Z] | (flags_q[F_S] ^ flags_q[F_V]);
               CC_BNE:  take = ~flags_q[F_Z];
               default: take = 1'b0;
            endcase
         end
      end
   end

   always_comb begin
      phase = '0;
      unique case (state_q)
         ST_P1:   phase = 5'b00001;
         ST_P2:   phase = 5'b00010;
         ST_P3:   phase = 5'b00100;
         ST_P4:   phase = 5'b01000;
         ST_P5:   phase = 5'b10000;
         default: phase = '0;
      endcase
   end

   assign running = |phase;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      wr_d    = wr_q;
      flags_d = flags_q;
      halt_d  = halt_q;
      req_d   = req_q;
      wren_d  = wren_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rf_d    = rf_q;
      // a stop request is remembered until the current instruction retires
      stop_d  = stop_q | (exec & running);
      unique case (state_q)
         ST_IDLE, ST_HALT: begin
            if (exec) begin
               state_d = ST_P1;
               halt_d  = 1'b0;
               req_d   = 1'b1;
               wren_d  = 1'b0;
               addr_d  = pc_q;
            end
         end
         ST_P1: begin
            if (m_ack) begin
               ir_d    = m_q[15:0];
               pc_d    = pc_q + ADDR_W'(1);
               req_d   = 1'b0;
               state_d = ST_P2;
            end
         end
         ST_P2: begin
            a_d     = rf_q[fa];
            b_d     = rf_q[fb];
            state_d = ST_P3;
         end
         ST_P3: begin
            state_d = ST_P4;
            if (cls == CL_ALU) begin
               res_d = alu_res;
               wr_d  = alu_wr;
               if (alu_fset) flags_d = alu_flg;
            end else if (cls == CL_MISC) begin
               res_d = sext8;
               wr_d  = (fa == MI_LI);
            end else begin
               // request is registered here so it is live on P4 entry
               wr_d    = (cls == CL_LD);
               req_d   = 1'b1;
               wren_d  = (cls == CL_ST);
               addr_d  = ea;
               wdata_d = a_q;
            end
         end
         ST_P4: begin
            if (!req_q || m_ack) begin
               if (req_q && !wren_q) res_d = m_q;
               req_d   = 1'b0;
               wren_d  = 1'b0;
               state_d = ST_P5;
            end
         end
         ST_P5: begin
            if (wr_q) rf_d[(cls == CL_LD) ? fa : fb] = res_q;
            if (take) pc_d = pc_q + sext8[ADDR_W-1:0];
            if (is_hlt) begin
               state_d = ST_HALT;
               halt_d  = 1'b1;
               stop_d  = 1'b0;
            end else if (stop_q || exec) begin
               state_d = ST_IDLE;
               stop_d  = 1'b0;
            end else begin
               state_d = ST_P1;
               req_d   = 1'b1;
               wren_d  = 1'b0;
               addr_d  = pc_d;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         wr_q    <= 1'b0;
         flags_q <= '0;
         stop_q  <= 1'b0;
         halt_q  <= 1'b0;
         req_q   <= 1'b0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rf_q    <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         wr_q    <= wr_d;
         flags_q <= flags_d;
         stop_q  <= stop_d;
         halt_q  <= halt_d;
         req_q   <= req_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rf_q    <= rf_d;
      end
   end

   assign m_req  = req_q;
   assign m_wren = wren_q;
   assign m_addr = addr_q;
   assign m_data = wdata_q;
   assign halted = halt_q;
   assign pc     = pc_q;
   assign flags  = flags_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: ALU vector table plus hand sequences
// for reset, handshake waits, branches, stop requests and HLT resume.
module tb_multicycle_core;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        exec  = 1'b0;
   logic [15:0] m_q   = '0;
   logic        m_ack = 1'b0;
   logic        m_req, m_wren;
   logic [11:0] m_addr, pc;
   logic [15:0] m_data;
   logic [4:0]  phase;
   logic        running, halted;
   logic [3:0]  flags;

   multicycle_core dut (
      .clock(clock), .reset(reset), .exec(exec),
      .m_q(m_q), .m_ack(m_ack), .m_req(m_req), .m_wren(m_wren),
      .m_addr(m_addr), .m_data(m_data), .phase(phase),
      .running(running), .halted(halted), .pc(pc), .flags(flags)
   );

   initial forever #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;

   // program image from the stimulus side; stores land in ram, tagged by epoch
   logic [15:0] rom [4096];
   logic [15:0] ram [4096];
   int          ram_ep [4096];
   int          epoch = 1;
   int          wait_n = 0;
   int          cnt = 0;
   int          hold_bad = 0;
   int          n_wr = 0;
   logic [11:0] w_addr = '0;
   logic [15:0] w_data = '0;
   logic [11:0] h_addr;
   logic        h_wren;
   logic [15:0] h_data;

   function automatic logic [15:0] rd(input logic [11:0] a);
      return (ram_ep[a] == epoch) ? ram[a] : rom[a];
   endfunction

   always @(negedge clock) begin
      if (!reset || !m_req) begin
         m_ack = 1'b0;
         cnt   = 0;
      end else begin
         if (cnt == 0) begin
            h_addr = m_addr;
            h_wren = m_wren;
            h_data = m_data;
         end else if ({m_addr, m_wren, m_data} !== {h_addr, h_wren, h_data}) begin
            hold_bad++;
         end
         if (cnt == wait_n) begin
            m_ack = 1'b1;
            cnt   = 0;
            m_q   = rd(m_addr);
            if (m_wren) begin
               ram[m_addr]    = m_data;
               ram_ep[m_addr] = epoch;
               n_wr++;
               w_addr = m_addr;
               w_data = m_data;
            end
         end else begin
            m_ack = 1'b0;
            cnt++;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic new_prog();
      epoch++;
      for (int i = 0; i < 4096; i++) rom[i] = '0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      exec  = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic kick();
      @(negedge clock) exec = 1'b1;
      @(posedge clock);
      #1 exec = 1'b0;
   endtask

   task automatic run(input int budget, output int cyc);
      kick();
      cyc = 0;
      while (!halted && cyc < budget) begin
         @(posedge clock);
         #1;
         cyc++;
      end
      if (!halted) begin
         n_vec++;
         n_bad++;
         $display("FAIL run timeout: halted=%0b after %0d cycles, required 1", halted, cyc);
      end
   endtask

   typedef struct packed {
      logic [3:0]  op;
      logic [3:0]  d;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] res;
      logic [3:0]  flg;
   } vec_t;

   vec_t tv [16];

   initial begin
      int cyc;
      int n0;
      // op, d, rd value, rs value, expected rd, expected {S,Z,C,V}
      tv[0]  = '{4'd0,  4'd0,  16'h0005, 16'hFFFD, 16'h0002, 4'b0010};
      tv[1]  = '{4'd0,  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
      tv[2]  = '{4'd1,  4'd0,  16'h0003, 16'h0005, 16'hFFFE, 4'b1010};
      tv[3]  = '{4'd1,  4'd0,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001};
      tv[4]  = '{4'd2,  4'd0,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
      tv[5]  = '{4'd3,  4'd0,  16'h8000, 16'h0001, 16'h8001, 4'b1000};
      tv[6]  = '{4'd4,  4'd0,  16'h1234, 16'h1234, 16'h0000, 4'b0100};
      tv[7]  = '{4'd5,  4'd0,  16'h0005, 16'h0005, 16'h0005, 4'b0100};
      tv[8]  = '{4'd6,  4'd0,  16'h1111, 16'hABCD, 16'hABCD, 4'b1000};
      tv[9]  = '{4'd8,  4'd1,  16'h8000, 16'h0000, 16'h0000, 4'b0110};
      tv[10] = '{4'd11, 4'd4,  16'h8010, 16'h0000, 16'hF801, 4'b1000};
      tv[11] = '{4'd10, 4'd1,  16'h8011, 16'h0000, 16'h4008, 4'b0010};
      tv[12] = '{4'd9,  4'd4,  16'h9001, 16'h0000, 16'h0019, 4'b0010};
      tv[13] = '{4'd8,  4'd0,  16'h8000, 16'h0000, 16'h8000, 4'b1000};
      tv[14] = '{4'd7,  4'd3,  16'h1234, 16'h5678, 16'h1234, 4'b0000};
      tv[15] = '{4'd11, 4'd15, 16'h4000, 16'h0000, 16'h0000, 4'b0110};

      // reset in the middle of a stalled fetch
      do_reset();
      new_prog();
      rom[0] = 16'h8105;
      rom[1] = 16'h8209;
      wait_n = 0;
      kick();
      @(posedge clock);
      #1 wait_n = 3;
      repeat (4) @(posedge clock);
      #1;
      chk("fetch1 req/addr", 64'({m_req, m_addr}), 64'({1'b1, 12'h001}));
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rst bus", 64'({m_req, m_wren, m_addr, m_data}), 64'(0));
      chk("rst status", 64'({phase, running, halted, pc, flags}), 64'(0));
      @(negedge clock);
      reset  = 1'b1;
      wait_n = 0;
      kick();
      chk("restart fetch", 64'({m_req, m_addr, phase, pc}), 64'({1'b1, 12'h000, 5'b00001, 12'h000}));

      // ALU/shift table: LD r1; LD r2; op r2->r1; ST r1; HLT
      for (int i = 0; i < 16; i++) begin
         do_reset();
         new_prog();
         rom[0]     = 16'h0840;
         rom[1]     = 16'h1041;
         rom[2]     = {8'hD1, tv[i].op, tv[i].d};
         rom[3]     = 16'h4842;
         rom[4]     = 16'hC0F0;
         rom[12'h40] = tv[i].x;
         rom[12'h41] = tv[i].y;
         run(100, cyc);
         chk($sformatf("v%0d res", i), 64'(rd(12'h042)), 64'(tv[i].res));
         chk($sformatf("v%0d flags", i), 64'(flags), 64'(tv[i].flg));
      end

      // LI/LI/ADD zero-wait, then resume to store r2
      do_reset();
      new_prog();
      rom[0] = 16'h8105;
      rom[1] = 16'h82FD;
      rom[2] = 16'hCA00;
      rom[3] = 16'hC0F0;
      rom[4] = 16'h5030;
      rom[5] = 16'hC0F0;
      run(100, cyc);
      chk("add seq cycles", 64'(cyc), 64'(20));
      chk("add seq flags", 64'(flags), 64'(4'b0010));
      chk("add seq halt", 64'({halted, running, phase, pc}), 64'({1'b1, 1'b0, 5'b0, 12'h004}));
      run(100, cyc);
      chk("add seq r2", 64'(rd(12'h030)), 64'(16'h0002));
      chk("resume pc", 64'(pc), 64'(12'h006));

      // store/load with two wait cycles on every request
      do_reset();
      new_prog();
      rom[0] = 16'h8105;
      rom[1] = 16'h4820;
      rom[2] = 16'h1820;
      rom[3] = 16'h5821;
      rom[4] = 16'hC0F0;
      wait_n = 2;
      n0 = n_wr;
      hold_bad = 0;
      run(200, cyc);
      chk("wait seq cycles", 64'(cyc), 64'(41));
      chk("st 0x20", 64'(rd(12'h020)), 64'(16'h0005));
      chk("ld r3 via st", 64'({w_addr, w_data}), 64'({12'h021, 16'h0005}));
      chk("write count", 64'(n_wr - n0), 64'(2));
      chk("held stable", 64'(hold_bad), 64'(0));
      wait_n = 0;

      // overflow then branches: BLT/BLE fall through, BNE taken to 8
      do_reset();
      new_prog();
      rom[0] = 16'h2040;
      rom[1] = 16'h8501;
      rom[2] = 16'hEC00;
      rom[3] = 16'hB902;
      rom[4] = 16'hBA02;
      rom[5] = 16'hBB02;
      rom[6] = 16'hC0F0;
      rom[7] = 16'hC0F0;
      rom[8] = 16'hC0F0;
      rom[12'h40] = 16'h7FFF;
      run(100, cyc);
      chk("branch pc", 64'(pc), 64'(12'h009));
      chk("ovf flags", 64'(flags), 64'(4'b1001));
      chk("branch cycles", 64'(cyc), 64'(35));

      // stop request in P3, then HLT and resume at next pc
      do_reset();
      new_prog();
      rom[0] = 16'h8107;
      rom[1] = 16'h8209;
      rom[2] = 16'hC0F0;
      rom[3] = 16'h5031;
      rom[4] = 16'hC0F0;
      kick();
      repeat (2) @(posedge clock);
      #1 exec = 1'b1;
      @(posedge clock);
      #1 exec = 1'b0;
      chk("stop p4", 64'({phase, running}), 64'({5'b01000, 1'b1}));
      @(posedge clock);
      #1;
      chk("stop p5", 64'({phase, running}), 64'({5'b10000, 1'b1}));
      @(posedge clock);
      #1;
      chk("stop idle", 64'({phase, running, halted, m_req, pc}), 64'({5'b0, 1'b0, 1'b0, 1'b0, 12'h001}));
      run(100, cyc);
      chk("hlt state", 64'({halted, running, phase, pc}), 64'({1'b1, 1'b0, 5'b0, 12'h003}));
      run(100, cyc);
      chk("resume st r2", 64'(rd(12'h031)), 64'(16'h0009));
      chk("resume end pc", 64'(pc), 64'(12'h005));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised successor to the five-phase 16-bit SIMPLE processor datapath.
- Merges phase sequencing and datapath into one clocked core. Adds stallable memory handshake, run/stop control, condition flags, load/store and branches.
- Sits between top-level panel/IO logic (exec button, status display) and a single-port unified instruction/data memory.

Parameters:
- DATA_W, 16, register/ALU/memory word width (must be >= 16; instruction is m_q[15:0]).
- ADDR_W, 12, memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- exec  in  1  single-cycle pulse: start from IDLE/HALT; stop request while running.
- m_q  in  DATA_W  memory read data, valid when m_ack=1.
- m_ack  in  1  memory completes the current request this cycle.
- m_req  out  1  memory request.
- m_wren  out  1  write enable, qualified by m_req.
- m_addr  out  ADDR_W  memory address.
- m_data  out  DATA_W  write data.
- phase  out  5  one-hot P1..P5; 0 when not running.
- running  out  1  core is executing.
- halted  out  1  HLT executed.
- pc  out  ADDR_W  current PC.
- flags  out  4  {S,Z,C,V}.

Behaviour:
- Reset (async, low): state=IDLE; pc=RESET_PC; r0..r7=0; flags=0; m_req=0; m_wren=0; m_addr=0; m_data=0; phase=0; running=0; halted=0.
- States: IDLE, P1 fetch, P2 decode/regread, P3 execute, P4 memory, P5 writeback, HALT.
  - IDLE/HALT + exec → P1; halted cleared.
  - P1→P2→P3→P4→P5→P1.
  - A stop request latches in the cycle exec arrives and is serviced at the end of P5 (→IDLE). The instruction always completes.
- Handshake:
  - m_req/m_addr/m_wren/m_data are registered and held stable until the cycle in which m_ack=1.
  - Zero-wait ack (ack in the first req cycle) is legal. Each wait cycle stalls the phase.
  - m_req drops in the cycle after ack.
- P1: m_addr=pc, read. On ack: IR<=m_q[15:0], pc<=pc+1 (wraps mod 2^ADDR_W).
- P2: decode IR; A<=R[IR13:11], B<=R[IR10:8].
- Encoding and P3 execution:
  - 11: ALU/shift. rs=[13:11], rd=[10:8], op=[7:4], d=[3:0].
    - Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 MOV, 8 SLL, 9 SLR (rotate left), 10 SRL, 11 SRA, 15 HLT.
    - Undefined op = NOP.
    - Results: rd<=rd op rs; shifts rd<=shift(rd,d); CMP updates flags only.
  - 00: LD rA<=mem[rB+sext(d8)].
  - 01: ST mem[rB+sext(d8)]<=rA. Effective address truncated to ADDR_W.
  - 10: [13:11]=000 LI rB<=sext(d8); 100 B pc<=pc+sext(d8); 111 conditional branch, cond [10:8]: 000 BE(Z), 001 BLT(S^V), 010 BLE(Z|(S^V)), 011 BNE(!Z).
    - Branch target is relative to the already-incremented pc. Others = NOP.
- Flags (DATA_W-bit arithmetic):
  - ADD/SUB/CMP set S,Z,C (carry out / borrow), V (signed overflow).
  - AND/OR/XOR/MOV set S,Z; clear C,V.
  - Shifts set S,Z; C = last bit shifted out (0 when d=0); V=0.
  - LD/ST/LI/branches leave flags unchanged.
- P4: LD/ST issue the memory request, stalling until ack; LD captures m_q into MDR. Other instructions pass in one cycle.
- P5: register write (ALU/shift/LI: result; LD: MDR); branch pc update.
  - HLT → HALT (running=0, halted=1, phase=0).
- Fixed instruction latency: 5 cycles at zero-wait. Each memory wait cycle adds 1.
- Reset mid-request: m_req drops immediately; the memory side must tolerate an abandoned request.

Decomposition:
- Shared package multicycle_pkg: state enum, opcode/op/cond constants, flag bit indices.
- One sub-module, core_alu: combinational ALU plus shifter producing result and flags.
- The register file stays inline as an 8xDATA_W array.

Test Plan:
- Reset low mid-fetch with m_req=1 → all outputs at reset values, pc=0; after release + exec, fetch at addr 0.
- LI r1,5; LI r2,-3; ADD r1,r2 (rd=r2) → r2=2, C=1, Z=0, S=0, V=0. Zero-wait: 15 cycles total.
- ST r1 at 0x20(r0), then LD r3,0x20(r0) with 2 wait cycles on every ack → m_wren=1 at addr 0x20 with data 5; r3=5; signals held stable across waits.
- LI r4,0x7F..; ADD overflow case 0x7FFF+1 → S=1, V=1; BLT +2 is not taken, BLE is not taken, BNE is taken.
- SRA r5,4 with r5=0x8010 → 0xF801, C=0; SLL r5,1 with 0x8000 → 0, Z=1, C=1.
- exec pulse during P3 → instruction completes, state→IDLE after P5. HLT → halted=1; exec resumes at the next pc.
